// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives PC to instruction memory, registers the returned byte into IF/ID,
// resolves relative jmp in fetch and stops fetching past the end of the loaded program.
module instruction_fetch_unit #(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned PROG_LEN   = 6,
    parameter logic [1:0]  JMP_OPCODE = 2'b11
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [7:0]          Instruction_Code,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                Redirect_En,
    input  logic [PC_WIDTH-1:0] Redirect_PC,
    output logic [PC_WIDTH-1:0] PC,
    output logic [7:0]          IF_ID_Instr,
    output logic [PC_WIDTH-1:0] IF_ID_PC,
    output logic                IF_ID_Valid,
    output logic                Halted
);

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OFF_W   = 6;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0]  if_pc_q, if_pc_d;
    logic                 valid_q, valid_d;

    logic                 fetch_ok_c;
    logic                 is_jmp_c;
    logic signed [OFF_W-1:0] jmp_off_c;
    logic [PC_WIDTH-1:0]  jmp_target_c;
    logic [PC_WIDTH-1:0]  next_pc_c;

    // Memory contents are only meaningful while RUN and inside the program.
    assign fetch_ok_c   = (state_q == ST_RUN) && (pc_q < PC_WIDTH'(PROG_LEN));
    assign is_jmp_c     = (Instruction_Code[7:6] == JMP_OPCODE);
    assign jmp_off_c    = $signed(Instruction_Code[OFF_W-1:0]);
    assign jmp_target_c = pc_q + PC_WIDTH'(jmp_off_c);
    assign next_pc_c    = is_jmp_c ? jmp_target_c : pc_q + PC_WIDTH'(1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= '0;
            if_pc_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
            valid_q <= valid_d;
        end
    end

    // Redirect always reopens fetch; running off the program end halts unless stalled.
    always_comb begin
        state_d = state_q;
        if (Redirect_En) begin
            state_d = ST_RUN;
        end else if (!Stall && (state_q == ST_RUN) && !fetch_ok_c) begin
            state_d = ST_HALT;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        valid_d = valid_q;
        if (Redirect_En) begin
            pc_d    = Redirect_PC;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (Flush) begin
            instr_d = '0;
            valid_d = 1'b0;
            if (!Stall && fetch_ok_c) begin
                pc_d = next_pc_c;
            end
        end else if (!Stall) begin
            if (fetch_ok_c) begin
                instr_d = Instruction_Code;
                if_pc_d = pc_q;
                valid_d = 1'b1;
                pc_d    = next_pc_c;
            end else begin
                instr_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    assign PC          = pc_q;
    assign IF_ID_Instr = instr_q;
    assign IF_ID_PC    = if_pc_q;
    assign IF_ID_Valid = valid_q;
    assign Halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench for instruction_fetch_unit against a behavioural model of the
// fetch stage plus fixed expectations from the reference program.
module tb_instruction_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Instruction_Code;
    logic       Stall;
    logic       Flush;
    logic       Redirect_En;
    logic [7:0] Redirect_PC;
    logic [7:0] PC;
    logic [7:0] IF_ID_Instr;
    logic [7:0] IF_ID_PC;
    logic       IF_ID_Valid;
    logic       Halted;

    logic [7:0] mem [0:7];

    typedef struct {
        logic [7:0] pc;
        logic [7:0] instr;
        logic [7:0] ifpc;
        logic       valid;
        logic       halt;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_pc, m_instr, m_ifpc;
    logic       m_valid, m_halt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] seq_pc    [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5};
    logic [7:0] seq_instr [5] = '{8'h13, 8'h51, 8'h2C, 8'hC2, 8'h0A};

    always #5 Clk = ~Clk;

    // Outside the program the memory returns a jmp so any stray sample is visible.
    assign Instruction_Code = (PC < 8'd6) ? mem[PC[2:0]] : 8'hFF;

    instruction_fetch_unit #(
        .PC_WIDTH  (8),
        .PROG_LEN  (6),
        .JMP_OPCODE(2'b11)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Instruction_Code(Instruction_Code),
        .Stall           (Stall),
        .Flush           (Flush),
        .Redirect_En     (Redirect_En),
        .Redirect_PC     (Redirect_PC),
        .PC              (PC),
        .IF_ID_Instr     (IF_ID_Instr),
        .IF_ID_PC        (IF_ID_PC),
        .IF_ID_Valid     (IF_ID_Valid),
        .Halted          (Halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    endtask

    task automatic load_program();
        mem[0] = 8'h13; mem[1] = 8'h51; mem[2] = 8'h2C; mem[3] = 8'hC2;
        mem[4] = 8'h6B; mem[5] = 8'h0A; mem[6] = 8'hFF; mem[7] = 8'hFF;
    endtask

    task automatic model_reset();
        m_pc = 8'd0; m_instr = 8'h00; m_ifpc = 8'd0; m_valid = 1'b0; m_halt = 1'b0;
    endtask

    // Expected post-edge state for the inputs about to be sampled.
    task automatic model_push(input logic st, input logic fl, input logic re, input logic [7:0] rpc);
        logic [7:0] c, off, npc;
        logic       in_prog;
        exp_t       e;
        in_prog = !m_halt && (m_pc < 8'd6);
        c   = mem[m_pc[2:0]];
        off = {{2{c[5]}}, c[5:0]};
        npc = (c[7:6] == 2'b11) ? m_pc + off : m_pc + 8'd1;
        if (re) begin
            m_pc = rpc; m_instr = 8'h00; m_valid = 1'b0; m_halt = 1'b0;
        end else if (fl) begin
            m_instr = 8'h00; m_valid = 1'b0;
            if (!st) begin
                if (in_prog) m_pc = npc;
                else m_halt = 1'b1;
            end
        end else if (!st) begin
            if (in_prog) begin
                m_instr = c; m_ifpc = m_pc; m_valid = 1'b1; m_pc = npc;
            end else begin
                m_instr = 8'h00; m_valid = 1'b0; m_halt = 1'b1;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.ifpc = m_ifpc; e.valid = m_valid; e.halt = m_halt;
        sb.push_back(e);
    endtask

    task automatic step(input logic st, input logic fl, input logic re, input logic [7:0] rpc);
        exp_t e;
        Stall = st; Flush = fl; Redirect_En = re; Redirect_PC = rpc;
        model_push(st, fl, re, rpc);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_pc",    32'(PC),          32'(e.pc));
        check_eq("sb_instr", 32'(IF_ID_Instr), 32'(e.instr));
        check_eq("sb_ifpc",  32'(IF_ID_PC),    32'(e.ifpc));
        check_eq("sb_valid", 32'(IF_ID_Valid), 32'(e.valid));
        check_eq("sb_halt",  32'(Halted),      32'(e.halt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        load_program();
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0; Redirect_En = 1'b0; Redirect_PC = 8'd0;
        #12;
        check_eq("rst_pc",    32'(PC),          32'd0);
        check_eq("rst_valid", 32'(IF_ID_Valid), 32'd0);
        check_eq("rst_instr", 32'(IF_ID_Instr), 32'h00);
        check_eq("rst_halt",  32'(Halted),      32'd0);
        model_reset();
        Reset = 1'b1;

        // Straight-line run; the jmp at 3 skips location 4.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0);
            check_eq("seq_ifpc",  32'(IF_ID_PC),    32'(seq_pc[i]));
            check_eq("seq_instr", 32'(IF_ID_Instr), 32'(seq_instr[i]));
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0);
            check_eq("halt_pc",    32'(PC),          32'd6);
            check_eq("halt_flag",  32'(Halted),      32'd1);
            check_eq("halt_valid", 32'(IF_ID_Valid), 32'd0);
        end

        // Redirect out of HALT wins over Stall.
        step(1'b1, 1'b0, 1'b1, 8'd1);
        check_eq("redir_pc",   32'(PC),     32'd1);
        check_eq("redir_halt", 32'(Halted), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("redir_instr", 32'(IF_ID_Instr), 32'h51);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'd0);
            check_eq("stall_pc",    32'(PC),          32'd2);
            check_eq("stall_instr", 32'(IF_ID_Instr), 32'h51);
        end
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("resume_ifpc",  32'(IF_ID_PC),    32'd2);
        check_eq("resume_instr", 32'(IF_ID_Instr), 32'h2C);

        // Flush bubble, then Flush+Stall holding PC.
        step(1'b0, 1'b0, 1'b1, 8'd1);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check_eq("flush_valid", 32'(IF_ID_Valid), 32'd0);
        check_eq("flush_pc",    32'(PC),          32'd2);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("flst_pc",    32'(PC),          32'd2);
        check_eq("flst_valid", 32'(IF_ID_Valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("postfl_instr", 32'(IF_ID_Instr), 32'h2C);

        // Jump-to-self, backward jump, jump past the program end.
        mem[4] = 8'hC0;
        step(1'b0, 1'b0, 1'b1, 8'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0);
            check_eq("self_pc",    32'(PC),          32'd4);
            check_eq("self_valid", 32'(IF_ID_Valid), 32'd1);
        end
        mem[4] = 8'hFC;
        step(1'b0, 1'b0, 1'b1, 8'd4);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("back_pc", 32'(PC), 32'd0);
        mem[5] = 8'hC3;
        step(1'b0, 1'b0, 1'b1, 8'd5);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("far_pc", 32'(PC), 32'd8);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("far_halt", 32'(Halted), 32'd1);
        check_eq("far_hold", 32'(PC),     32'd8);
        load_program();

        // Mixed random traffic.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 7)));
        end

        // Asynchronous reset mid-cycle at PC=3.
        step(1'b0, 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("pre_arst_pc", 32'(PC), 32'd3);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("arst_pc",    32'(PC),          32'd0);
        check_eq("arst_valid", 32'(IF_ID_Valid), 32'd0);
        check_eq("arst_instr", 32'(IF_ID_Instr), 32'h00);
        check_eq("arst_halt",  32'(Halted),      32'd0);
        model_reset();
        #2;
        Reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("restart_ifpc",  32'(IF_ID_PC),    32'd0);
        check_eq("restart_instr", 32'(IF_ID_Instr), 32'h13);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
